// File: rtl/mem_port_arbiter.sv
// N-to-1 round-robin arbiter for core memory ports onto one shared memory port.
// Read ownership is tracked in an in-order FIFO so responses route back to the issuing port.
module mem_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_PORTS-1:0]                 S_RDEN,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      S_RIADDR,
  input  logic [NUM_PORTS-1:0]                 S_WREN,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  S_WSTRB,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      S_WADDR,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      S_WDATA,
  output logic [NUM_PORTS-1:0]                 S_WAIT,
  output logic [NUM_PORTS-1:0]                 S_RVALID,
  output logic [ADDR_WIDTH-1:0]                S_ROADDR,
  output logic [DATA_WIDTH-1:0]                S_RDATA,
  output logic                                 MEM_RDEN,
  output logic [ADDR_WIDTH-1:0]                MEM_RIADDR,
  input  logic                                 MEM_RVALID,
  input  logic [ADDR_WIDTH-1:0]                MEM_ROADDR,
  input  logic [DATA_WIDTH-1:0]                MEM_RDATA,
  output logic                                 MEM_WREN,
  output logic [DATA_WIDTH/8-1:0]              MEM_WSTRB,
  output logic [ADDR_WIDTH-1:0]                MEM_WADDR,
  output logic [DATA_WIDTH-1:0]                MEM_WDATA,
  input  logic                                 MEM_WAIT,
  output logic [$clog2(MAX_OUTSTANDING):0]     PENDING,
  output logic                                 ERR_SPURIOUS
);

  localparam int STRB  = DATA_WIDTH / 8;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int FW    = $clog2(MAX_OUTSTANDING);
  localparam int CW    = FW + 1;

  logic [NUM_PORTS-1:0] req;
  logic [PTR_W-1:0]     rr_ptr;
  logic                 grant_valid;
  logic [PTR_W-1:0]     grant_idx;
  logic                 gr_rden;
  logic                 gr_wren;
  logic                 full;
  logic                 rd_blocked;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [FW-1:0]        wr_ptr;
  logic [FW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 err_q;
  logic [PTR_W-1:0]     fifo_q [MAX_OUTSTANDING];

  assign req = S_RDEN | S_WREN;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
      end
    end
  end

  assign gr_rden    = S_RDEN[grant_idx];
  assign gr_wren    = S_WREN[grant_idx];
  assign full       = (count == CW'(MAX_OUTSTANDING));
  assign rd_blocked = grant_valid & gr_rden & full;
  assign accept     = ~RST & grant_valid & ~MEM_WAIT & ~rd_blocked;
  assign push       = accept & gr_rden;
  assign pop        = ~RST & MEM_RVALID & (count != '0);

  // A blocked read also holds back its paired write so the write is not issued twice.
  assign MEM_RDEN   = ~RST & grant_valid & gr_rden & ~full;
  assign MEM_WREN   = ~RST & grant_valid & gr_wren & ~rd_blocked;
  assign MEM_RIADDR = S_RIADDR[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign MEM_WADDR  = S_WADDR[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign MEM_WDATA  = S_WDATA[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign MEM_WSTRB  = S_WSTRB[int'(grant_idx)*STRB +: STRB];

  assign S_ROADDR     = MEM_ROADDR;
  assign S_RDATA      = MEM_RDATA;
  assign PENDING      = count;
  assign ERR_SPURIOUS = err_q;

  always_comb begin
    S_WAIT = '1;
    if (accept) S_WAIT[grant_idx] = 1'b0;
  end

  always_comb begin
    S_RVALID = '0;
    if (pop) S_RVALID[fifo_q[rd_ptr]] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept)
        rr_ptr <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (MEM_RVALID && count == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr] <= grant_idx;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (2 ports, 4 outstanding reads, 32-bit address/data).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  S_RDEN, S_WREN, S_WAIT, S_RVALID;
  logic [63:0] S_RIADDR, S_WADDR, S_WDATA;
  logic [7:0]  S_WSTRB;
  logic [31:0] S_ROADDR, S_RDATA;
  logic        MEM_RDEN, MEM_RVALID, MEM_WREN, MEM_WAIT;
  logic [31:0] MEM_RIADDR, MEM_ROADDR, MEM_RDATA, MEM_WADDR, MEM_WDATA;
  logic [3:0]  MEM_WSTRB;
  logic [2:0]  PENDING;
  logic        ERR_SPURIOUS;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .S_RDEN(S_RDEN), .S_RIADDR(S_RIADDR), .S_WREN(S_WREN), .S_WSTRB(S_WSTRB),
    .S_WADDR(S_WADDR), .S_WDATA(S_WDATA), .S_WAIT(S_WAIT), .S_RVALID(S_RVALID),
    .S_ROADDR(S_ROADDR), .S_RDATA(S_RDATA),
    .MEM_RDEN(MEM_RDEN), .MEM_RIADDR(MEM_RIADDR), .MEM_RVALID(MEM_RVALID),
    .MEM_ROADDR(MEM_ROADDR), .MEM_RDATA(MEM_RDATA), .MEM_WREN(MEM_WREN),
    .MEM_WSTRB(MEM_WSTRB), .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WAIT(MEM_WAIT), .PENDING(PENDING), .ERR_SPURIOUS(ERR_SPURIOUS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [1:0] exp_rv [4];
    exp_rv[0] = 2'b01; exp_rv[1] = 2'b10; exp_rv[2] = 2'b01; exp_rv[3] = 2'b10;

    RST = 1'b1; S_RDEN = 2'b11; S_WREN = 2'b00; S_WSTRB = '0;
    S_RIADDR = {32'h200, 32'h100}; S_WADDR = '0; S_WDATA = '0;
    MEM_RVALID = 1'b0; MEM_ROADDR = '0; MEM_RDATA = '0; MEM_WAIT = 1'b0;
    tick();
    #1;
    chk("rst_pending", PENDING, 0);
    chk("rst_err", ERR_SPURIOUS, 0);
    chk("rst_swait", S_WAIT, 2'b11);
    chk("rst_mem_rden", MEM_RDEN, 0);

    // single read from port 0, latency 2
    tick();
    RST = 1'b0; S_RDEN = 2'b01; S_RIADDR = {32'h0, 32'h1000};
    #1;
    chk("t1_mem_rden", MEM_RDEN, 1);
    chk("t1_mem_addr", MEM_RIADDR, 32'h1000);
    chk("t1_swait", S_WAIT, 2'b10);
    tick();
    S_RDEN = 2'b00;
    #1;
    chk("t1_pending1", PENDING, 1);
    chk("t1_rden_idle", MEM_RDEN, 0);
    tick();
    MEM_RVALID = 1'b1; MEM_RDATA = 32'hDEADBEEF; MEM_ROADDR = 32'h1000;
    #1;
    chk("t1_rvalid", S_RVALID, 2'b01);
    chk("t1_rdata", S_RDATA, 32'hDEADBEEF);
    chk("t1_roaddr", S_ROADDR, 32'h1000);
    tick();
    MEM_RVALID = 1'b0;
    #1;
    chk("t1_pending0", PENDING, 0);
    chk("t1_err", ERR_SPURIOUS, 0);

    // reset pulse so round-robin restarts at port 0, then alternate grants
    RST = 1'b1;
    tick();
    RST = 1'b0; S_RDEN = 2'b11; S_RIADDR = {32'h200, 32'h100};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_swait", S_WAIT, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("t2_addr", MEM_RIADDR, (k % 2 == 0) ? 32'h100 : 32'h200);
      tick();
    end
    S_RDEN = 2'b00;
    #1;
    chk("t2_pending4", PENDING, 4);
    for (int k = 0; k < 4; k++) begin
      MEM_RVALID = 1'b1; MEM_RDATA = 32'hA0 + k;
      #1;
      chk("t2_route", S_RVALID, exp_rv[k]);
      tick();
    end
    MEM_RVALID = 1'b0;
    #1;
    chk("t2_pending0", PENDING, 0);

    // port 1 read stalled by MEM_WAIT for 3 cycles
    S_RDEN = 2'b10; S_RIADDR = {32'h2468, 32'h0}; MEM_WAIT = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_swait_stall", S_WAIT, 2'b11);
      chk("t3_mem_rden", MEM_RDEN, 1);
      chk("t3_pending_stall", PENDING, 0);
      tick();
    end
    MEM_WAIT = 1'b0;
    #1;
    chk("t3_swait_acc", S_WAIT, 2'b01);
    tick();
    S_RDEN = 2'b00;
    #1;
    chk("t3_pending1", PENDING, 1);
    tick();
    MEM_RVALID = 1'b1;
    #1;
    chk("t3_route", S_RVALID, 2'b10);
    tick();
    MEM_RVALID = 1'b0;

    // fill the FIFO from port 0, then a port 1 write gets through
    S_RDEN = 2'b01; S_RIADDR = {32'h0, 32'h4000};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_swait_fill", S_WAIT, 2'b10);
      tick();
    end
    #1;
    chk("t4_pending_full", PENDING, 4);
    chk("t4_swait_full", S_WAIT, 2'b11);
    chk("t4_rden_full", MEM_RDEN, 0);
    tick();
    S_WREN = 2'b10; S_WADDR = {32'h300, 32'h0}; S_WDATA = {32'hCAFEF00D, 32'h0};
    S_WSTRB = 8'hF0;
    #1;
    chk("t4_wr_swait", S_WAIT, 2'b01);
    chk("t4_wren", MEM_WREN, 1);
    chk("t4_waddr", MEM_WADDR, 32'h300);
    chk("t4_wdata", MEM_WDATA, 32'hCAFEF00D);
    chk("t4_wstrb", MEM_WSTRB, 4'hF);
    chk("t4_wr_rden", MEM_RDEN, 0);
    tick();
    S_WREN = 2'b00;
    MEM_RVALID = 1'b1;
    #1;
    chk("t4_pop_noblock", S_WAIT, 2'b11);
    chk("t4_pop_rv", S_RVALID, 2'b01);
    tick();
    #1;
    chk("t4_pending3", PENDING, 3);
    chk("t4_swait_acc", S_WAIT, 2'b10);
    chk("t4_pushpop_rv", S_RVALID, 2'b01);
    tick();
    S_RDEN = 2'b00; MEM_RVALID = 1'b0;
    #1;
    chk("t4_pending_pp", PENDING, 3);

    // reset with 3 outstanding
    RST = 1'b1; S_RDEN = 2'b11;
    #1;
    chk("t5_rst_swait", S_WAIT, 2'b11);
    chk("t5_rst_rden", MEM_RDEN, 0);
    tick();
    RST = 1'b0;
    #1;
    chk("t5_pending0", PENDING, 0);
    chk("t5_rr_restart", S_WAIT, 2'b10);
    tick();
    S_RDEN = 2'b00; RST = 1'b1;
    tick();
    RST = 1'b0;

    // late response after reset is spurious
    MEM_RVALID = 1'b1;
    #1;
    chk("t6_no_rvalid", S_RVALID, 2'b00);
    tick();
    MEM_RVALID = 1'b0;
    #1;
    chk("t6_err_set", ERR_SPURIOUS, 1);
    tick();
    tick();
    #1;
    chk("t6_err_held", ERR_SPURIOUS, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("t6_err_clr", ERR_SPURIOUS, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-to-1 arbiter joining the instruction/data memory ports of several requesters (cores, MMU walkers, DMA) onto one shared memory port.
- Read and write channels use the core memory convention: RDEN/RIADDR request, RVALID/ROADDR/RDATA response, WREN/WSTRB/WADDR/WDATA write, and a WAIT stall.
- Adds round-robin arbitration, per-port stall generation and in-order response routing through an outstanding-read ID FIFO.
- Sits between the per-hart core instances and the memory/bus bridge.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
MAX_OUTSTANDING, 4, depth of the read-owner FIFO (power of two, >=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (multiple of 8); STRB = DATA_WIDTH/8

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous, active-high reset
S_RDEN  in  NUM_PORTS  per-port read request
S_RIADDR  in  NUM_PORTS*ADDR_WIDTH  per-port read address, port i at [i*AW +: AW]
S_WREN  in  NUM_PORTS  per-port write request
S_WSTRB  in  NUM_PORTS*STRB  per-port byte strobes
S_WADDR  in  NUM_PORTS*ADDR_WIDTH  per-port write address
S_WDATA  in  NUM_PORTS*DATA_WIDTH  per-port write data
S_WAIT  out  NUM_PORTS  per-port stall: request not accepted this cycle
S_RVALID  out  NUM_PORTS  per-port read-response strobe (one-hot or zero)
S_ROADDR  out  ADDR_WIDTH  response address, broadcast to all ports
S_RDATA  out  DATA_WIDTH  response data, broadcast to all ports
MEM_RDEN  out  1  downstream read request
MEM_RIADDR  out  ADDR_WIDTH  downstream read address
MEM_RVALID  in  1  downstream read response
MEM_ROADDR  in  ADDR_WIDTH  downstream response address
MEM_RDATA  in  DATA_WIDTH  downstream response data
MEM_WREN  out  1  downstream write request
MEM_WSTRB  out  STRB  downstream strobes
MEM_WADDR  out  ADDR_WIDTH  downstream write address
MEM_WDATA  out  DATA_WIDTH  downstream write data
MEM_WAIT  in  1  downstream stall
PENDING  out  clog2(MAX_OUTSTANDING)+1  outstanding read count
ERR_SPURIOUS  out  1  sticky: MEM_RVALID seen with FIFO empty

Behaviour:
- Reset (RST=1 at edge): rr pointer=0, FIFO empty, PENDING=0, ERR_SPURIOUS=0.
- While RST is high: MEM_RDEN=MEM_WREN=0, S_RVALID=0, S_WAIT=all 1.
- Port i requests when S_RDEN[i] or S_WREN[i] is set. The requester holds all request signals stable while S_WAIT[i]=1.
- Grant is combinational, same cycle, round-robin: the first requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
- Only the granted port drives MEM_*. Its read and write are forwarded together in the same cycle. MEM_RDEN/MEM_WREN=0 when there is no grant.
- A read is blocked (MEM_RDEN forced 0) when the FIFO is full. A pop in the same cycle does not unblock it.
- Accept: grant exists, MEM_WAIT=0, and the read is not blocked (only relevant if the granted port has S_RDEN=1).
- S_WAIT[i]=0 only for the granted port in its accept cycle; 1 otherwise. A write-only port is never blocked by a full FIFO.
- On accept: rr pointer <= grant+1 (mod NUM_PORTS). With no accept the pointer holds.
- On an accepted read: push the granted port index.
- MEM_RVALID=1 with FIFO non-empty: S_RVALID[head]=1 in the same cycle (combinational), then pop.
- S_ROADDR/S_RDATA always mirror MEM_ROADDR/MEM_RDATA.
- Memory returns reads in order with latency >=1. A response in the same cycle as a push to an empty FIFO therefore counts as spurious.
- MEM_RVALID=1 with FIFO empty: response dropped, S_RVALID=0, ERR_SPURIOUS<=1 (cleared only by reset).
- Push and pop in the same cycle: PENDING unchanged, pointers both advance.
- NUM_PORTS=1: grant = request, pointer stays 0.
- Reset mid-operation discards all outstanding owners. Late responses after reset set ERR_SPURIOUS.

Test Plan:
- Single port 0 read of 0x1000, memory latency 2, data 0xDEADBEEF -> MEM_RDEN one cycle; S_RVALID=01 two cycles later with S_RDATA=0xDEADBEEF; PENDING 0->1->0.
- Both ports request reads continuously, MEM_WAIT=0 -> grants alternate 0,1,0,1; each port sees S_WAIT high on alternate cycles; responses route to ports in issue order.
- Port 1 reads with MEM_WAIT high for 3 cycles -> S_WAIT[1]=1 for 3 cycles, rr pointer unchanged, accepted on cycle 4, one push only.
- MAX_OUTSTANDING=4, no responses, port 0 issues 5 reads -> 4 accepted, 5th stalls (PENDING=4); a port 1 write during the stall is accepted.
- MEM_RVALID pulsed with PENDING=0 -> no S_RVALID, ERR_SPURIOUS=1 held until RST.
- RST asserted with PENDING=3 -> next cycle PENDING=0, S_WAIT all 1 while RST high, round-robin restarts at port 0.
